// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: FSM state encoding
//   and default values for the PC step and the PC loaded at reset.
// ----------------------------------------------------------------------------
package fetch_pkg;

    // RUN : free to issue a request
    // WAIT: exactly one request outstanding to instruction memory
    // HALT: sticky stop, left only by a redirect or reset
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          DEFAULT_PC_STEP  = 2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO holding fetched {next_pc, pc, instr} tuples.
//   The head entry is visible combinationally on rdata whenever count != 0.
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   flush        empties the FIFO; wins over push and pop in the same cycle
//   push, wdata  write one entry (ignored when full unless a pop frees a slot)
//   pop          remove the head entry (ignored when empty)
//   rdata        head entry
//   count        number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full FIFO may still accept a write when the head leaves this cycle.
        do_push  = push && ((count_q != DEPTH_C) || do_pop);
        wr_en    = do_push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_pipe.sv
// ----------------------------------------------------------------------------
// fetch_pipe
//   Decoupled instruction-fetch stage. Owns the PC, issues one word request
//   at a time to a variable-latency instruction memory, and buffers returned
//   {pc, instr, pc+PC_STEP} tuples for decode. Redirects flush the buffer and
//   squash any in-flight response through a one-bit epoch tag.
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    load a new PC, flush, squash in-flight fetch
//   halt_in                        sticky request to stop issuing fetches
//   imem_req, imem_addr            request strobe and address to memory
//   imem_valid, imem_rdata         response strobe and data from memory
//   out_valid, out_ready           head-of-buffer handshake with decode
//   out_instr, out_pc, out_next_pc head tuple
//   halted                         halted with nothing outstanding
// ----------------------------------------------------------------------------
module fetch_pipe
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_next_pc,
    output logic               halted
);

    localparam int ENTRY_W = 2 * ADDR_W + INSTR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wait_pc_q, wait_pc_d;   // PC of the outstanding request
    logic              epoch_q, epoch_d;
    logic              tag_q, tag_d;           // epoch the outstanding request belongs to
    logic              halt_q, halt_d;

    logic               resp;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_eff;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               issue;

    always_comb begin
        resp      = (state_q == ST_WAIT) && imem_valid;
        // Redirect squashes a response arriving in the same cycle.
        fifo_push = resp && (tag_q == epoch_q) && !redirect_valid;
        fifo_pop  = (fifo_count != '0) && out_ready && !redirect_valid;
        // Occupancy after this cycle's push/pop; a response cycle may issue
        // the next request as long as a slot is still free for it.
        count_eff = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        issue     = !rst && !redirect_valid && !halt_q &&
                    (((state_q == ST_RUN) && (fifo_count < DEPTH_C)) ||
                     (resp && (count_eff < DEPTH_C)));

        pc_d      = pc_q;
        wait_pc_d = wait_pc_q;
        tag_d     = tag_q;
        epoch_d   = epoch_q ^ redirect_valid;
        halt_d    = redirect_valid ? 1'b0 : (halt_q | halt_in);

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d      = pc_q + STEP_C;
            wait_pc_d = pc_q;
            tag_d     = epoch_q;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (issue) begin
                    state_d = ST_WAIT;
                end else if (!redirect_valid && halt_q) begin
                    state_d = ST_HALT;
                end
            end
            ST_WAIT: begin
                // A redirect here leaves the request outstanding; its stale
                // response is dropped when it arrives.
                if (imem_valid) begin
                    if (issue) begin
                        state_d = ST_WAIT;
                    end else if (!redirect_valid && halt_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            wait_pc_q <= RESET_PC;
            epoch_q   <= 1'b0;
            tag_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wait_pc_q <= wait_pc_d;
            epoch_q   <= epoch_d;
            tag_q     <= tag_d;
            halt_q    <= halt_d;
        end
    end

    // next_pc is stored with the entry so decode sees it without an adder.
    assign fifo_wdata = {wait_pc_q + STEP_C, wait_pc_q, imem_rdata};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign out_valid   = (fifo_count != '0);
    assign out_next_pc = fifo_rdata[ENTRY_W-1 -: ADDR_W];
    assign out_pc      = fifo_rdata[INSTR_W +: ADDR_W];
    assign out_instr   = fifo_rdata[INSTR_W-1:0];
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pipe.sv
// ----------------------------------------------------------------------------
// tb_fetch_pipe
//   Directed bench for fetch_pipe. A main instance (RESET_PC 0) is driven
//   through streaming, back-pressure, redirect, halt and reset scenarios; a
//   second instance (RESET_PC FFFE) exercises PC wrap-around. Memory returns
//   instr = addr ^ 16'hC3C3 after a programmable latency.
// ----------------------------------------------------------------------------
module tb_fetch_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt_in = 1'b0;
    logic        out_ready = 1'b1;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        out_valid;
    logic [15:0] out_instr, out_pc, out_next_pc;
    logic        halted;

    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic        w_imem_valid = 1'b0;
    logic [15:0] w_imem_rdata = 16'h0;
    logic        w_out_valid;
    logic [15:0] w_out_instr, w_out_pc, w_out_next_pc;
    logic        w_halted;

    int          lat = 1;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic [15:0] pend_addr = 16'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pipe #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_in(halt_in),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_next_pc(out_next_pc),
        .halted(halted)
    );

    fetch_pipe #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .halt_in(1'b0),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_valid(w_imem_valid), .imem_rdata(w_imem_rdata),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_next_pc(w_out_next_pc),
        .halted(w_halted)
    );

    // Main memory model: response arrives 'lat' cycles after the request.
    always @(posedge clk) begin
        imem_valid <= 1'b0;
        if (imem_req) begin
            if (lat <= 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= imem_addr ^ 16'hC3C3;
            end else begin
                busy      <= 1'b1;
                cnt       <= lat - 1;
                pend_addr <= imem_addr;
            end
        end else if (busy) begin
            if (cnt == 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= pend_addr ^ 16'hC3C3;
                busy       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Wrap-test memory: fixed one-cycle latency.
    always @(posedge clk) begin
        w_imem_valid <= w_imem_req;
        if (w_imem_req) begin
            w_imem_rdata <= w_imem_addr ^ 16'hC3C3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_w_valid", {31'd0, w_out_valid}, 32'd0);
        repeat (2) @(posedge clk);

        // C0: leave reset, first request at RESET_PC
        cyc(); rst = 1'b0; #1;
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", {16'd0, imem_addr}, 32'h0000);
        chk("c0_w_addr", {16'd0, w_imem_addr}, 32'hFFFE);
        // C1: response + back-to-back issue
        cyc(); #1;
        chk("c1_addr", {16'd0, imem_addr}, 32'h0002);
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        // C2
        cyc(); #1;
        chk("c2_pc", {16'd0, out_pc}, 32'h0000);
        chk("c2_instr", {16'd0, out_instr}, 32'hC3C3);
        chk("c2_next", {16'd0, out_next_pc}, 32'h0002);
        chk("c2_addr", {16'd0, imem_addr}, 32'h0004);
        chk("c2_w_pc", {16'd0, w_out_pc}, 32'hFFFE);
        chk("c2_w_next", {16'd0, w_out_next_pc}, 32'h0000);
        chk("c2_w_instr", {16'd0, w_out_instr}, 32'h3C3D);
        // C3
        cyc(); #1;
        chk("c3_pc", {16'd0, out_pc}, 32'h0002);
        chk("c3_instr", {16'd0, out_instr}, 32'hC3C1);
        chk("c3_addr", {16'd0, imem_addr}, 32'h0006);
        chk("c3_w_pc", {16'd0, w_out_pc}, 32'h0000);
        chk("c3_w_next", {16'd0, w_out_next_pc}, 32'h0002);

        // C4: redirect to 0 with decode stalled (back-pressure scenario)
        cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0000; out_ready = 1'b0; #1;
        chk("c4_req", {31'd0, imem_req}, 32'd0);
        // C5
        cyc(); redirect_valid = 1'b0; #1;
        chk("c5_valid", {31'd0, out_valid}, 32'd0);
        chk("c5_req", {31'd0, imem_req}, 32'd1);
        chk("c5_addr", {16'd0, imem_addr}, 32'h0000);
        // C6
        cyc(); #1;
        chk("c6_addr", {16'd0, imem_addr}, 32'h0002);
        // C7..C9: buffer fills, no more requests
        cyc(); #1;
        chk("c7_req", {31'd0, imem_req}, 32'd0);
        chk("c7_pc", {16'd0, out_pc}, 32'h0000);
        cyc(); #1;
        chk("c8_req", {31'd0, imem_req}, 32'd0);
        cyc(); #1;
        chk("c9_req", {31'd0, imem_req}, 32'd0);
        chk("c9_pc", {16'd0, out_pc}, 32'h0000);
        // C10: release ready
        cyc(); out_ready = 1'b1; #1;
        // C11
        cyc(); #1;
        chk("c11_pc", {16'd0, out_pc}, 32'h0002);
        chk("c11_req", {31'd0, imem_req}, 32'd1);
        chk("c11_addr", {16'd0, imem_addr}, 32'h0004);
        // C12
        cyc(); #1;
        chk("c12_addr", {16'd0, imem_addr}, 32'h0006);
        // C13: next request goes out with 3-cycle latency
        cyc(); lat = 3; #1;
        chk("c13_pc", {16'd0, out_pc}, 32'h0004);
        chk("c13_instr", {16'd0, out_instr}, 32'hC3C7);
        chk("c13_addr", {16'd0, imem_addr}, 32'h0008);
        // C14: redirect while waiting on address 8
        cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0100; #1;
        chk("c14_req", {31'd0, imem_req}, 32'd0);
        // C15
        cyc(); redirect_valid = 1'b0; #1;
        chk("c15_valid", {31'd0, out_valid}, 32'd0);
        chk("c15_req", {31'd0, imem_req}, 32'd0);
        // C16: stale response dropped, target issued in the same cycle
        cyc(); #1;
        chk("c16_req", {31'd0, imem_req}, 32'd1);
        chk("c16_addr", {16'd0, imem_addr}, 32'h0100);
        cyc(); #1;
        chk("c17_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        // C19: response for 0100
        cyc(); #1;
        chk("c19_addr", {16'd0, imem_addr}, 32'h0102);
        // C20
        cyc(); lat = 1; #1;
        chk("c20_pc", {16'd0, out_pc}, 32'h0100);
        chk("c20_instr", {16'd0, out_instr}, 32'hC2C3);
        chk("c20_next", {16'd0, out_next_pc}, 32'h0102);
        cyc(); #1;
        // C22
        cyc(); #1;
        chk("c22_addr", {16'd0, imem_addr}, 32'h0104);
        // C23: redirect together with a response and a pop
        cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0200; #1;
        chk("c23_pc", {16'd0, out_pc}, 32'h0102);
        chk("c23_req", {31'd0, imem_req}, 32'd0);
        // C24
        cyc(); redirect_valid = 1'b0; #1;
        chk("c24_valid", {31'd0, out_valid}, 32'd0);
        chk("c24_req", {31'd0, imem_req}, 32'd1);
        chk("c24_addr", {16'd0, imem_addr}, 32'h0200);
        cyc(); #1;
        // C26: raise halt
        cyc(); halt_in = 1'b1; #1;
        chk("c26_pc", {16'd0, out_pc}, 32'h0200);
        chk("c26_addr", {16'd0, imem_addr}, 32'h0204);
        // C27: halt in effect while waiting on 0204
        cyc(); halt_in = 1'b0; out_ready = 1'b0; #1;
        chk("c27_req", {31'd0, imem_req}, 32'd0);
        chk("c27_halted", {31'd0, halted}, 32'd0);
        // C28
        cyc(); #1;
        chk("c28_halted", {31'd0, halted}, 32'd1);
        chk("c28_req", {31'd0, imem_req}, 32'd0);
        chk("c28_pc", {16'd0, out_pc}, 32'h0202);
        // C29
        cyc(); out_ready = 1'b1; #1;
        chk("c29_halted", {31'd0, halted}, 32'd1);
        chk("c29_req", {31'd0, imem_req}, 32'd0);
        // C30: buffered response still delivered
        cyc(); #1;
        chk("c30_pc", {16'd0, out_pc}, 32'h0204);
        chk("c30_instr", {16'd0, out_instr}, 32'hC1C7);
        chk("c30_req", {31'd0, imem_req}, 32'd0);
        // C31: redirect resumes
        cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0300; lat = 4; #1;
        chk("c31_valid", {31'd0, out_valid}, 32'd0);
        chk("c31_halted", {31'd0, halted}, 32'd1);
        // C32
        cyc(); redirect_valid = 1'b0; #1;
        chk("c32_halted", {31'd0, halted}, 32'd0);
        chk("c32_req", {31'd0, imem_req}, 32'd1);
        chk("c32_addr", {16'd0, imem_addr}, 32'h0300);
        // C33: asynchronous reset mid-WAIT
        cyc(); rst = 1'b1; #1;
        chk("c33_req", {31'd0, imem_req}, 32'd0);
        chk("c33_valid", {31'd0, out_valid}, 32'd0);
        chk("c33_halted", {31'd0, halted}, 32'd0);
        // C34..C36: late response lands while reset is held
        cyc(); #1;
        cyc(); #1;
        cyc(); #1;
        chk("c36_valid", {31'd0, out_valid}, 32'd0);
        // C37: release reset
        cyc(); rst = 1'b0; lat = 1; #1;
        chk("c37_req", {31'd0, imem_req}, 32'd1);
        chk("c37_addr", {16'd0, imem_addr}, 32'h0000);
        chk("c37_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        chk("c38_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #1;
        chk("c39_pc", {16'd0, out_pc}, 32'h0000);
        chk("c39_instr", {16'd0, out_instr}, 32'hC3C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
